// File: rtl/alsaqr_noc_link_arbiter.sv
// Packet-atomic round-robin arbiter for a credit-based NoC output link, one registered flit stage.
// Optional per-requester header counters when ALSAQR_LINK_ARB_STATS_EN is defined.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module alsaqr_noc_link_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int CREDITS   = 4,
    parameter int LEN_LSB   = 22,
    parameter int LEN_WIDTH = 8,
    localparam int ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ*`DATA_WIDTH-1:0] data_in,
    input  logic [NUM_REQ-1:0]             valid_in,
    output logic [NUM_REQ-1:0]             ready_in,
    output logic [`DATA_WIDTH-1:0]         data_out,
    output logic                           valid_out,
    input  logic                           yummy_out,
    output logic [ID_W-1:0]                grant_id,
    output logic                           busy,
    output logic                           credit_err
`ifdef ALSAQR_LINK_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]          pkt_count,
    input  logic                           stats_clr
`endif
);

    localparam int          DW      = `DATA_WIDTH;
    localparam int unsigned NR      = NUM_REQ;
    localparam logic [3:0]  CRED_MAX = 4'(CREDITS);

    typedef enum logic {IDLE, BODY} state_t;

    state_t                 state, state_n;
    logic [3:0]             credit, credit_n;
    logic                   err_n;
    logic [ID_W-1:0]        rr_ptr, rr_n, gid_n;
    logic [LEN_WIDTH-1:0]   remaining, rem_n;
    logic [ID_W-1:0]        winner, sel;
    logic                   found, accept;
    logic [DW-1:0]          flit;
    logic [LEN_WIDTH-1:0]   hdr_len;

    function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
        next_id = (32'(id) + 1 == NR) ? '0 : ID_W'(id + 1'b1);
    endfunction

    always_comb begin
        int unsigned idx;
        idx    = 0;
        found  = 1'b0;
        winner = '0;
        for (int unsigned k = 0; k < NR; k++) begin
            idx = (32'(rr_ptr) + k) % NR;
            if (!found && valid_in[idx]) begin
                found  = 1'b1;
                winner = ID_W'(idx);
            end
        end
    end

    // Mid-packet the owner is locked; ready is gated by reset so it reads 0 during reset.
    assign sel     = (state == BODY) ? grant_id : winner;
    assign flit    = data_in[32'(sel)*DW +: DW];
    assign hdr_len = flit[LEN_LSB +: LEN_WIDTH];
    assign busy    = (state == BODY);

    always_comb begin
        ready_in = '0;
        if (reset && (credit != '0) && (state == BODY || found))
            ready_in[sel] = 1'b1;
    end

    assign accept = |(valid_in & ready_in);

    always_comb begin
        state_n = state;
        rem_n   = remaining;
        rr_n    = rr_ptr;
        gid_n   = grant_id;
        if (accept) begin
            unique case (state)
                IDLE: begin
                    gid_n = winner;
                    if (hdr_len == '0) begin
                        rr_n = next_id(winner);
                    end else begin
                        rem_n   = hdr_len;
                        state_n = BODY;
                    end
                end
                BODY: begin
                    rem_n = remaining - 1'b1;
                    if (remaining == LEN_WIDTH'(1)) begin
                        rr_n    = next_id(grant_id);
                        state_n = IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        credit_n = credit;
        err_n    = credit_err;
        unique case ({accept, yummy_out})
            2'b10: credit_n = credit - 4'd1;
            2'b01: begin
                if (credit == CRED_MAX) err_n = 1'b1;
                else                    credit_n = credit + 4'd1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            credit     <= CRED_MAX;
            credit_err <= 1'b0;
            rr_ptr     <= '0;
            remaining  <= '0;
            grant_id   <= '0;
            valid_out  <= 1'b0;
            data_out   <= '0;
        end else begin
            state      <= state_n;
            credit     <= credit_n;
            credit_err <= err_n;
            rr_ptr     <= rr_n;
            remaining  <= rem_n;
            grant_id   <= gid_n;
            valid_out  <= accept;
            if (accept) data_out <= flit;
        end
    end

`ifdef ALSAQR_LINK_ARB_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pkt_count <= '0;
        end else if (stats_clr) begin
            pkt_count <= '0;
        end else if (accept && state == IDLE &&
                     pkt_count[32'(winner)*16 +: 16] != 16'hFFFF) begin
            pkt_count[32'(winner)*16 +: 16] <= pkt_count[32'(winner)*16 +: 16] + 16'd1;
        end
    end
`endif

endmodule
